router_fifo: RTL and testbench
==============================

Name: router_fifo

Overview:
- Per-destination output buffer of the 1x4 router, one instance per output port (0..3). Sits directly downstream of the synchronizer.
- Accepts the one-hot write_enb bit for its port and the soft_reset_N timeout pulse.
- Buffers packet bytes and tags each packet's header byte.
- Returns full and empty to the synchronizer, which uses them for fifo_full and vld_out_N. Tracks packet boundaries on the read side.

Parameters:
- DATA_WIDTH, 8, byte width of the packet datapath.
- DEPTH, 16, number of entries; must be a power of two, at least 2.
- ADDR_WIDTH, $clog2(DEPTH), pointer index width.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- soft_reset  in  1  synchronous flush; a one-cycle pulse from the synchronizer timeout.
- write_enb  in  1  write request; this port's bit of the synchronizer write_enb[3:0].
- read_enb  in  1  read request from the destination client.
- lfd_state  in  1  marks the byte being written as a packet header.
- data_in  in  DATA_WIDTH  write data.
- data_out  out  DATA_WIDTH  registered read data.
- full  out  1  occupancy equals DEPTH.
- empty  out  1  occupancy equals 0.
- pkt_busy  out  1  read side is inside a packet (remaining count is non-zero).

Behaviour:
- Storage: DEPTH entries of DATA_WIDTH+1 bits. The extra MSB holds lfd_state captured on write.
- Pointers: wr_ptr and rd_ptr are ADDR_WIDTH bits and wrap from DEPTH-1 to 0. A separate occupancy counter is ADDR_WIDTH+1 bits wide.
- full and empty are decoded combinationally from occupancy and are not registered.
- Write accept: write_enb and not full, with full evaluated before the edge. Writes {lfd_state, data_in} at wr_ptr, then increments wr_ptr.
- Read accept: read_enb and not empty. data_out takes mem[rd_ptr] data bits on the same edge, giving 1-cycle latency from read_enb to data_out. rd_ptr then increments.
- No read accepted: data_out holds its previous value.
- Simultaneous accepted read and write: occupancy is unchanged.
- Write while full: dropped; occupancy, pointers and memory are unchanged. A read in the same cycle is still performed.
- Read while empty: ignored, and data_out holds. A write in the same cycle is still performed.
- Packet count: rem_cnt is 7 bits, initialised to 0.
  - On an accepted read of an entry whose lfd bit is 1: rem_cnt <= data[7:2] + 1, covering payload length plus the parity byte.
  - On an accepted read of a non-header entry: rem_cnt decrements if non-zero and saturates at 0.
  - pkt_busy = (rem_cnt != 0).
- reset (priority 1) and soft_reset (priority 2) clear the same state:
  - wr_ptr, rd_ptr, occupancy, rem_cnt and data_out all go to 0.
  - As a result, empty=1, full=0 and pkt_busy=0.
  - Memory contents are not cleared.
  - Any write or read in that cycle is discarded.
- reset or soft_reset in the middle of a packet: the partial packet is lost and no residual count remains.
- There is no state machine beyond the pointer and counter registers.

Decomposition:
- router_pkg holds:
  - DATA_WIDTH and FIFO_DEPTH constants;
  - header field constants: HDR_LEN_MSB=7, HDR_LEN_LSB=2, HDR_ADDR_MSB=1, HDR_ADDR_LSB=0;
  - SOFT_RESET_TIMEOUT=30;
  - the fifo_entry_t struct {logic lfd; logic [DATA_WIDTH-1:0] data;}.
- One sub-module is natural: router_fifo_mem, a DEPTH x fifo_entry_t register array with one write port and one read port. It has synchronous write and a combinational read address, with no reset.

Test Plan:
1. Reset: hold reset=1 for 2 cycles, then release -> empty=1, full=0, data_out=8'h00, pkt_busy=0.
2. Fill and overflow: 16 writes of 8'h01..8'h10, then a 17th write of 8'hAA -> full=1 after the 16th write and the 17th is dropped. 16 reads then return 8'h01..8'h10, each one cycle after its read_enb, and end with empty=1.
3. Packet tracking: write header 8'h0D (len=3, addr=1) with lfd_state=1, then 3 payload bytes and 1 parity byte. Read all 5 -> rem_cnt goes 4,3,2,1,0, pkt_busy=1 during the reads and pkt_busy=0 after the 5th.
4. Simultaneous read and write at full: occupancy 16, read_enb=1, write_enb=1 -> read returns the oldest entry, the write is dropped and occupancy=15. Repeat at occupancy 8 -> occupancy stays 8.
5. Soft reset mid-packet: 3 of 5 packet bytes read, then a soft_reset pulse -> next cycle empty=1, pkt_busy=0, data_out=8'h00. The next header is tracked from a fresh count.
6. Pointer wrap: 40 interleaved write/read pairs with random data -> output order is preserved across wraps and full never asserts.

Source files
------------

// File: rtl/router_pkg.sv
// Shared constants and entry layout for the router datapath.
package router_pkg;

    localparam int unsigned DATA_WIDTH         = 8;
    localparam int unsigned FIFO_DEPTH         = 16;
    localparam int unsigned HDR_LEN_MSB        = 7;
    localparam int unsigned HDR_LEN_LSB        = 2;
    localparam int unsigned HDR_ADDR_MSB       = 1;
    localparam int unsigned HDR_ADDR_LSB       = 0;
    localparam int unsigned SOFT_RESET_TIMEOUT = 30;

    typedef struct packed {
        logic                  lfd;
        logic [DATA_WIDTH-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/router_fifo_mem.sv
// Entry storage for router_fifo: synchronous write, combinational read, no reset.
module router_fifo_mem
    import router_pkg::*;
#(
    parameter int unsigned DEPTH      = FIFO_DEPTH,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  fifo_entry_t           wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output fifo_entry_t           rd_data
);

    fifo_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/router_fifo.sv
// Per-port output buffer of the 1x4 router; tags headers and tracks packet
// boundaries on the read side.
module router_fifo
    import router_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = router_pkg::DATA_WIDTH,
    parameter int unsigned DEPTH      = router_pkg::FIFO_DEPTH,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  soft_reset,
    input  logic                  write_enb,
    input  logic                  read_enb,
    input  logic                  lfd_state,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  pkt_busy
);

    localparam int unsigned CNT_W = ADDR_WIDTH + 1;
    localparam int unsigned REM_W = 7;

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CNT_W-1:0]      occupancy;
    logic [REM_W-1:0]      rem_cnt;
    logic                  flush;
    logic                  wr_acc;
    logic                  rd_acc;
    fifo_entry_t           wr_entry;
    fifo_entry_t           rd_entry;

    assign full     = (occupancy == CNT_W'(DEPTH));
    assign empty    = (occupancy == '0);
    assign pkt_busy = (rem_cnt != '0);

    assign flush    = reset || soft_reset;
    assign wr_acc   = write_enb && !full;
    assign rd_acc   = read_enb && !empty;

    assign wr_entry.lfd  = lfd_state;
    assign wr_entry.data = data_in;

    // Writes in a flush cycle are discarded so memory stays untouched.
    router_fifo_mem #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc && !flush),
        .wr_addr (wr_ptr),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr),
        .rd_data (rd_entry)
    );

    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            rem_cnt   <= '0;
            data_out  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (rd_acc) begin
                rd_ptr   <= rd_ptr + ADDR_WIDTH'(1);
                data_out <= rd_entry.data;
                // Header reload covers payload length plus the trailing parity byte.
                if (rd_entry.lfd) begin
                    rem_cnt <= REM_W'(rd_entry.data[HDR_LEN_MSB:HDR_LEN_LSB]) + REM_W'(1);
                end else if (rem_cnt != '0) begin
                    rem_cnt <= rem_cnt - REM_W'(1);
                end
            end
            case ({wr_acc, rd_acc})
                2'b10:   occupancy <= occupancy + CNT_W'(1);
                2'b01:   occupancy <= occupancy - CNT_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

endmodule

// File: tb/tb_router_fifo.sv
// Directed self-checking bench for router_fifo.
module tb_router_fifo;

    logic       clk = 1'b0;
    logic       reset, soft_reset, write_enb, read_enb, lfd_state;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       full, empty, pkt_busy;

    int n_checks = 0;
    int n_fail   = 0;

    router_fifo dut (
        .clk        (clk),
        .reset      (reset),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .read_enb   (read_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .data_out   (data_out),
        .full       (full),
        .empty      (empty),
        .pkt_busy   (pkt_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, srst, we, re, lfd;
        logic [7:0] din;
        logic [7:0] exp_dout;
        logic       exp_full, exp_empty, exp_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic step(input logic rst, input logic srst, input logic we,
                        input logic re, input logic lfd, input logic [7:0] din);
        reset      = rst;
        soft_reset = srst;
        write_enb  = we;
        read_enb   = re;
        lfd_state  = lfd;
        data_in    = din;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [7:0] dout,
                             input logic f, input logic e, input logic b);
        check({name, ".data_out"}, data_out, dout);
        check({name, ".full"},     8'(full), 8'(f));
        check({name, ".empty"},    8'(empty), 8'(e));
        check({name, ".pkt_busy"}, 8'(pkt_busy), 8'(b));
    endtask

    function automatic vec_t mk(input logic rst, input logic srst, input logic we,
                                input logic re, input logic lfd, input logic [7:0] din,
                                input logic [7:0] dout, input logic f, input logic e,
                                input logic b);
        vec_t v;
        v.rst = rst; v.srst = srst; v.we = we; v.re = re; v.lfd = lfd; v.din = din;
        v.exp_dout = dout; v.exp_full = f; v.exp_empty = e; v.exp_busy = b;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] model_q[$];
        logic [7:0] d, exp_d;

        reset = 1'b1; soft_reset = 1'b0; write_enb = 1'b0; read_enb = 1'b0;
        lfd_state = 1'b0; data_in = 8'h00;
        @(negedge clk);

        // rst srst we re lfd din      dout  full empty busy
        // reset (write in the same cycle is discarded), then packet tracking
        vecs.push_back(mk(1, 0, 1, 0, 0, 8'h55, 8'h00, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 8'h0D, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 8'h11, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 8'h22, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 8'h33, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 8'h44, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 8'h00, 8'h0D, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 8'h00, 8'h11, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 8'h00, 8'h22, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 8'h00, 8'h33, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 8'h00, 8'h44, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 8'h00, 8'h44, 0, 1, 0));
        // soft reset mid-packet, then a fresh header (len=2)
        vecs.push_back(mk(0, 0, 1, 0, 1, 8'h0D, 8'h44, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 8'h11, 8'h44, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 8'h22, 8'h44, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 8'h33, 8'h44, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 8'h44, 8'h44, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 8'h00, 8'h0D, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 8'h00, 8'h11, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 8'h00, 8'h22, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 1, 0, 8'h99, 8'h00, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 8'h09, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 8'hA1, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 8'h00, 8'h09, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 8'h00, 8'hA1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 8'h00, 8'hA1, 0, 1, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0));

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].srst, vecs[i].we, vecs[i].re, vecs[i].lfd, vecs[i].din);
            check_all($sformatf("vec%0d", i), vecs[i].exp_dout, vecs[i].exp_full,
                      vecs[i].exp_empty, vecs[i].exp_busy);
        end

        // fill to full, overflow write dropped, drain in order
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 1, 0, 0, 8'(i + 1));
            check_all($sformatf("fill%0d", i), 8'h00, (i == 15), 1'b0, 1'b0);
        end
        step(0, 0, 1, 0, 0, 8'hAA);
        check_all("overflow", 8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 0, 1, 0, 8'h00);
            check_all($sformatf("drain%0d", i), 8'(i + 1), 1'b0, (i == 15), 1'b0);
        end
        step(0, 0, 0, 1, 0, 8'h00);
        check_all("read_empty_hold", 8'h10, 1'b0, 1'b1, 1'b0);

        // simultaneous read+write at full: write dropped, occupancy 15
        for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 0, 8'(8'h20 + i));
        check_all("full2", 8'h10, 1'b1, 1'b0, 1'b0);
        step(0, 0, 1, 1, 0, 8'hBB);
        check_all("rw_full", 8'h20, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i < 16; i++) begin
            step(0, 0, 0, 1, 0, 8'h00);
            check_all($sformatf("rw_full_drain%0d", i), 8'(8'h20 + i), 1'b0, (i == 15), 1'b0);
        end

        // simultaneous read+write at occupancy 8: occupancy stays 8
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 0, 8'(8'h30 + i));
        step(0, 0, 1, 1, 0, 8'h38);
        check_all("rw_mid", 8'h30, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i < 9; i++) begin
            step(0, 0, 0, 1, 0, 8'h00);
            check_all($sformatf("rw_mid_drain%0d", i), 8'(8'h30 + i), 1'b0, (i == 8), 1'b0);
        end

        // pointer wrap: prefill two, then 40 simultaneous write/read pairs
        exp_d = 8'h38;
        for (int i = 0; i < 2; i++) begin
            d = 8'($urandom_range(0, 255));
            model_q.push_back(d);
            step(0, 0, 1, 0, 0, d);
        end
        for (int i = 0; i < 40; i++) begin
            d = 8'($urandom_range(0, 255));
            model_q.push_back(d);
            exp_d = model_q.pop_front();
            step(0, 0, 1, 1, 0, d);
            check_all($sformatf("wrap%0d", i), exp_d, 1'b0, 1'b0, 1'b0);
        end
        while (model_q.size() > 0) begin
            exp_d = model_q.pop_front();
            step(0, 0, 0, 1, 0, 8'h00);
            check_all("wrap_drain", exp_d, 1'b0, (model_q.size() == 0), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
